// File: rtl/system_pkg.sv
// Shared types and helpers for the instruction-fetch arbiter.
//  arb_mode_e  : arbitration policy selector (fixed priority / round-robin)
//  core_idx_t  : generic core index, wide enough for up to max_cores_c cores
//  rr_select() : first set bit of valid_vec at or after ptr, scanning upward with wrap
package system_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int unsigned max_cores_c  = 32;
    localparam int unsigned core_idx_w_c = 5;

    typedef logic [core_idx_w_c-1:0] core_idx_t;

    // Returns ptr when nothing in the first n bits is set; callers qualify with |valid_vec.
    function automatic core_idx_t rr_select(
        input logic [max_cores_c-1:0] valid_vec,
        input core_idx_t              ptr,
        input int unsigned            n
    );
        core_idx_t   res;
        logic        found;
        int unsigned idx;
        res   = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < max_cores_c; k++) begin
            // ptr < n and k < n, so a single subtraction performs the wrap
            idx = 32'(ptr) + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((k < n) && !found && valid_vec[idx[core_idx_w_c-1:0]]) begin
                found = 1'b1;
                res   = core_idx_w_c'(idx);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO holding the issuing-core index of each in-flight fetch.
// Ports:
//  clk_i, reset_i  clock, synchronous active-high reset
//  push_i, data_i  write request and data (ignored when full)
//  pop_i, data_o   read request (ignored when empty) and head-of-queue data
//  full_o, empty_o occupancy flags; push and pop in the same cycle are legal
module sync_fifo #(
    parameter int unsigned width_p = 2,
    parameter int unsigned depth_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               push_i,
    input  logic [width_p-1:0] data_i,
    input  logic               pop_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int unsigned ptr_w = (depth_p > 1) ? $clog2(depth_p) : 1;
    localparam int unsigned cnt_w = $clog2(depth_p + 1);

    logic [width_p-1:0] mem [depth_p];
    logic [ptr_w-1:0]   wr_ptr;
    logic [ptr_w-1:0]   rd_ptr;
    logic [cnt_w-1:0]   count;
    logic               do_push;
    logic               do_pop;

    function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(depth_p - 1)) ? '0 : p + ptr_w'(1);
    endfunction

    assign full_o  = (count == cnt_w'(depth_p));
    assign empty_o = (count == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem[rd_ptr];

    // Pointer and occupancy tracking
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + cnt_w'(1);
            end else if (do_pop && !do_push) begin
                count <= count - cnt_w'(1);
            end
        end
    end

    // Storage needs no reset: entries are only read after being written
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

endmodule

// File: rtl/instr_fetch_arbiter.sv
// Shares one instruction-memory port among num_cores_p core fetch ports.
// Requests are arbitrated (round-robin or fixed priority), held stable while the
// memory stalls, and in-order responses are steered back through an ID FIFO.
// Per-core outstanding counters gate fence.i flush acknowledges.
// Ports:
//  clk_i, reset_i                 clock, synchronous active-high reset
//  instr_valid_i / instr_ready_o  per-core request / grant
//  instr_addr_i                   per-core fetch address
//  instr_valid_o / instr_rdata_o  per-core response valid (one-hot) / data
//  flush_req_i / flush_ack_o      per-core fence.i flush handshake
//  mem_valid_o / mem_ready_i      memory request handshake, mem_addr_o address
//  mem_valid_i / mem_rdata_i      in-order memory response
//  err_o                          sticky: response with nothing outstanding
module instr_fetch_arbiter
    import system_pkg::*;
#(
    parameter int unsigned num_cores_p       = 4,
    parameter int unsigned max_outstanding_p = 4,
    parameter int unsigned rr_mode_p         = 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [num_cores_p-1:0]      instr_valid_i,
    output logic [num_cores_p-1:0]      instr_ready_o,
    input  logic [num_cores_p-1:0][31:0] instr_addr_i,
    output logic [num_cores_p-1:0]      instr_valid_o,
    output logic [num_cores_p-1:0][31:0] instr_rdata_o,
    input  logic [num_cores_p-1:0]      flush_req_i,
    output logic [num_cores_p-1:0]      flush_ack_o,
    output logic                        mem_valid_o,
    input  logic                        mem_ready_i,
    output logic [31:0]                 mem_addr_o,
    input  logic                        mem_valid_i,
    input  logic [31:0]                 mem_rdata_i,
    output logic                        err_o
);

    localparam int unsigned idx_w = (num_cores_p > 1) ? $clog2(num_cores_p) : 1;
    localparam int unsigned cnt_w = $clog2(max_outstanding_p + 1);
    localparam arb_mode_e   arb_mode = (rr_mode_p != 0) ? ARB_RR : ARB_FIXED;

    // Registered state and its next values
    logic                               lock;
    logic                               lock_d;
    logic [idx_w-1:0]                   lock_idx;
    logic [idx_w-1:0]                   lock_idx_d;
    logic [idx_w-1:0]                   rr_ptr;
    logic [idx_w-1:0]                   rr_ptr_d;
    logic                               err_q;
    logic                               err_d;
    logic [num_cores_p-1:0][cnt_w-1:0]  outstanding;
    logic [num_cores_p-1:0][cnt_w-1:0]  outstanding_d;

    // Combinational datapath
    logic [num_cores_p-1:0]             eligible;
    logic [max_cores_c-1:0]             elig_wide;
    logic [idx_w-1:0]                   sel;
    logic                               sel_valid;
    logic                               handshake;
    logic                               pop;
    logic                               spurious;
    logic [num_cores_p-1:0]             inc_vec;
    logic [num_cores_p-1:0]             dec_vec;
    logic [idx_w-1:0]                   fifo_head;
    logic                               fifo_full;
    logic                               fifo_empty;

    // Request selection: a held lock overrides arbitration and flush masking
    always_comb begin
        eligible  = instr_valid_i & ~flush_req_i;
        elig_wide = max_cores_c'(eligible);
        if (lock) begin
            sel = lock_idx;
        end else if (arb_mode == ARB_RR) begin
            sel = idx_w'(rr_select(elig_wide, core_idx_w_c'(rr_ptr), num_cores_p));
        end else begin
            sel = idx_w'(rr_select(elig_wide, '0, num_cores_p));
        end
        // Full blocks issue even when a pop lands in the same cycle
        sel_valid = ~fifo_full & (lock | (|eligible));
        handshake = sel_valid & mem_ready_i & ~reset_i;
        pop       = mem_valid_i & ~fifo_empty & ~reset_i;
        spurious  = mem_valid_i & fifo_empty & ~reset_i;
    end

    sync_fifo #(
        .width_p (idx_w),
        .depth_p (max_outstanding_p)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (handshake),
        .data_i  (sel),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lock        <= 1'b0;
            lock_idx    <= '0;
            rr_ptr      <= '0;
            err_q       <= 1'b0;
            outstanding <= '0;
        end else begin
            lock        <= lock_d;
            lock_idx    <= lock_idx_d;
            rr_ptr      <= rr_ptr_d;
            err_q       <= err_d;
            outstanding <= outstanding_d;
        end
    end

    // Next-state: lock, round-robin pointer, sticky error, per-core counters
    always_comb begin
        lock_d        = lock;
        lock_idx_d    = lock_idx;
        rr_ptr_d      = rr_ptr;
        err_d         = err_q;
        outstanding_d = outstanding;
        inc_vec       = '0;
        dec_vec       = '0;

        if (sel_valid && !mem_ready_i) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end else if (handshake) begin
            lock_d = 1'b0;
        end

        if (handshake && (arb_mode == ARB_RR)) begin
            rr_ptr_d = (sel == idx_w'(num_cores_p - 1)) ? '0 : sel + idx_w'(1);
        end

        if (spurious) begin
            err_d = 1'b1;
        end

        // Same-core push and pop cancel; the FIFO bound keeps counters from wrapping
        for (int c = 0; c < int'(num_cores_p); c++) begin
            inc_vec[c] = handshake & (sel == idx_w'(c));
            dec_vec[c] = pop & (fifo_head == idx_w'(c));
            if (inc_vec[c] && !dec_vec[c]) begin
                outstanding_d[c] = outstanding[c] + cnt_w'(1);
            end else if (dec_vec[c] && !inc_vec[c]) begin
                outstanding_d[c] = outstanding[c] - cnt_w'(1);
            end
        end
    end

    // Outputs: zero-latency grant/response steering, all forced low during reset
    always_comb begin
        mem_valid_o   = 1'b0;
        mem_addr_o    = '0;
        instr_ready_o = '0;
        instr_valid_o = '0;
        instr_rdata_o = '0;
        flush_ack_o   = '0;
        err_o         = 1'b0;
        if (!reset_i) begin
            mem_valid_o = sel_valid;
            if (sel_valid) begin
                mem_addr_o         = instr_addr_i[sel];
                instr_ready_o[sel] = mem_ready_i;
            end
            if (pop) begin
                instr_valid_o[fifo_head] = 1'b1;
            end
            for (int c = 0; c < int'(num_cores_p); c++) begin
                instr_rdata_o[c] = mem_rdata_i;
                // A core locked mid-handshake is not drained yet
                flush_ack_o[c]   = flush_req_i[c] & (outstanding[c] == '0)
                                   & ~(lock & (lock_idx == idx_w'(c)));
            end
            err_o = err_q;
        end
    end

endmodule
